// File: rtl/butterfly_resp.sv
// -----------------------------------------------------------------------------
// butterfly_resp
// Streaming responder for NTT butterflies over Z_q (default q = 8380417).
// Accepts (a, b, twiddle, mode) on a valid/ready handshake, computes either
// the forward Cooley-Tukey or the inverse Gentleman-Sande butterfly in a
// 3-stage pipeline, and returns (a', b') on a valid/ready handshake with
// full backpressure.
//
//   CT (sel=0): t = b*w mod Q;  a' = a + t;  b' = a - t            (mod Q)
//   GS (sel=1): a' = a + b;     b' = (a - b) * w                   (mod Q)
//
// Ports
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  operand handshake
//   a_i, b_i, twiddle_i      operands (residues in [0, Q-1])
//   sel_butterfly_i          0 = CT (forward), 1 = GS (inverse)
//   out_valid_o/out_ready_i  result handshake
//   a_o, b_o                 results a', b'
//   range_err_o              an operand of this result was >= Q
//   count_o                  results accepted by the consumer (wraps)
//
// Pipeline
//   S1: operands, range flag, GS sum and difference
//   S2: 2W-bit product (CT: b*w, GS: (a-b)*w)
//   S3: reduced product and final CT add/sub; drives the outputs
//   All stages move together on advance = !v3 || out_ready_i.
// -----------------------------------------------------------------------------
module butterfly_resp #(
   parameter int unsigned Q = 8380417,
   parameter int unsigned W = 23
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] twiddle_i,
   input  logic         sel_butterfly_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] a_o,
   output logic [W-1:0] b_o,
   output logic         range_err_o,
   output logic [15:0]  count_o
);

   localparam logic [W:0]     QW  = (W+1)'(Q);
   localparam logic [W-1:0]   QN  = W'(Q);
   localparam logic [2*W-1:0] Q2W = (2*W)'(Q);

   // (x + y) mod Q for x, y in [0, Q-1]: W+1-bit sum, one conditional subtract.
   function automatic logic [W-1:0] add_mod(input logic [W-1:0] x,
                                           input logic [W-1:0] y);
      logic [W:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= QW) s = s - QW;
      return W'(s);
   endfunction

   // (x - y) mod Q for x, y in [0, Q-1]: add Q back on borrow.
   function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x,
                                           input logic [W-1:0] y);
      logic [W:0] d;
      if (x >= y) d = {1'b0, x} - {1'b0, y};
      else        d = {1'b0, x} + QW - {1'b0, y};
      return W'(d);
   endfunction

   // Full reduction of a 2W-bit product by the constant modulus.
   function automatic logic [W-1:0] red_mod(input logic [2*W-1:0] p);
      logic [2*W-1:0] r;
      r = p % Q2W;
      return W'(r);
   endfunction

   // ---------------------------------------------------------------- control
   logic advance;
   logic in_fire;
   logic out_fire;
   logic v1_q, v2_q, v3_q;

   assign advance    = !v3_q || out_ready_i;
   assign in_ready_o = advance;
   assign in_fire    = in_valid_i && advance;
   assign out_fire   = v3_q && out_ready_i;

   // ---------------------------------------------------------------- stage 1
   logic [W-1:0] a1_q, x1_q, w1_q, sum1_q;
   logic         sel1_q, err1_q;
   logic [W-1:0] x1_d;
   logic         err1_d;

   // GS difference replaces b as the multiplicand; CT multiplies b directly.
   assign x1_d   = sel_butterfly_i ? sub_mod(a_i, b_i) : b_i;
   assign err1_d = (a_i >= QN) || (b_i >= QN) || (twiddle_i >= QN);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and the stages shift without races.
   // NOTE: data registers are reset too, because a_o/b_o/range_err_o must
   // read 0 out of reset, not just the valid bits.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         v1_q   <= 1'b0;
         a1_q   <= '0;
         x1_q   <= '0;
         w1_q   <= '0;
         sum1_q <= '0;
         sel1_q <= 1'b0;
         err1_q <= 1'b0;
      end else if (advance) begin
         v1_q <= in_fire;
         // Operands are captured only on a real transfer.
         if (in_fire) begin
            a1_q   <= a_i;
            x1_q   <= x1_d;
            w1_q   <= twiddle_i;
            sum1_q <= add_mod(a_i, b_i);
            sel1_q <= sel_butterfly_i;
            err1_q <= err1_d;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [W-1:0]   a2_q, sum2_q;
   logic [2*W-1:0] prod2_q;
   logic           sel2_q, err2_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         v2_q    <= 1'b0;
         a2_q    <= '0;
         sum2_q  <= '0;
         prod2_q <= '0;
         sel2_q  <= 1'b0;
         err2_q  <= 1'b0;
      end else if (advance) begin
         v2_q <= v1_q;
         if (v1_q) begin
            a2_q    <= a1_q;
            sum2_q  <= sum1_q;
            prod2_q <= (2*W)'(x1_q) * (2*W)'(w1_q);
            sel2_q  <= sel1_q;
            err2_q  <= err1_q;
         end
      end
   end

   // ---------------------------------------------------------------- stage 3
   logic [W-1:0] a3_q, b3_q;
   logic         err3_q;
   logic [W-1:0] t3;
   logic [W-1:0] a3_d, b3_d;

   assign t3 = red_mod(prod2_q);

   // NOTE: both outputs get a value on every path, so no latch is inferred.
   always_comb begin
      a3_d = sum2_q;
      b3_d = t3;
      if (!sel2_q) begin
         a3_d = add_mod(a2_q, t3);
         b3_d = sub_mod(a2_q, t3);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         v3_q   <= 1'b0;
         a3_q   <= '0;
         b3_q   <= '0;
         err3_q <= 1'b0;
      end else if (advance) begin
         v3_q <= v2_q;
         // Outputs change only on advance, so a stalled result holds steady.
         if (v2_q) begin
            a3_q   <= a3_d;
            b3_q   <= b3_d;
            err3_q <= err2_q;
         end
      end
   end

   // ---------------------------------------------------------------- counter
   logic [15:0] count_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)      count_q <= '0;
      else if (out_fire) count_q <= count_q + 16'd1;
   end

   assign out_valid_o = v3_q;
   assign a_o         = a3_q;
   assign b_o         = b3_q;
   assign range_err_o = err3_q;
   assign count_o     = count_q;

endmodule

// File: tb/tb_butterfly_resp.sv
// -----------------------------------------------------------------------------
// tb_butterfly_resp
// Self-checking bench for butterfly_resp. Inputs are driven once per cycle;
// outputs are sampled on the falling edge. Expected results come from a plain
// modular-arithmetic model and are held in a FIFO scoreboard in acceptance
// order.
// -----------------------------------------------------------------------------
module tb_butterfly_resp;

   localparam int unsigned Q = 8380417;
   localparam int unsigned W = 23;

   typedef struct {
      longint a;
      longint b;
      bit     err;
      int     acc_edge;
      bit     lat_chk;
   } exp_t;

   logic         clk_i = 1'b0;
   logic         rst_n_i = 1'b0;
   logic         in_valid_i = 1'b0;
   logic         in_ready_o;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic [W-1:0] twiddle_i = '0;
   logic         sel_butterfly_i = 1'b0;
   logic         out_valid_o;
   logic         out_ready_i = 1'b0;
   logic [W-1:0] a_o;
   logic [W-1:0] b_o;
   logic         range_err_o;
   logic [15:0]  count_o;

   butterfly_resp #(.Q(Q), .W(W)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .a_i            (a_i),
      .b_i            (b_i),
      .twiddle_i      (twiddle_i),
      .sel_butterfly_i(sel_butterfly_i),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .a_o            (a_o),
      .b_o            (b_o),
      .range_err_o    (range_err_o),
      .count_o        (count_o)
   );

   always #5 clk_i = ~clk_i;

   int           errors = 0;
   int           checks = 0;
   exp_t         exp_q[$];
   logic [15:0]  exp_count = '0;
   int           cyc = 0;
   bit           check_lat = 1'b0;
   bit           hold_v = 1'b0;
   logic [W-1:0] hold_a, hold_b;
   logic         hold_e;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference butterfly in plain integer arithmetic.
   function automatic exp_t model(input longint a, input longint b,
                                  input longint w, input bit sel);
      exp_t   r;
      longint q = longint'(Q);
      longint t, d;
      if (!sel) begin
         t   = (b * w) % q;
         r.a = (a + t) % q;
         r.b = (a - t + q) % q;
      end else begin
         r.a = (a + b) % q;
         d   = (a - b + q) % q;
         r.b = (d * w) % q;
      end
      r.err      = (a >= q) || (b >= q) || (w >= q);
      r.acc_edge = 0;
      r.lat_chk  = 1'b0;
      return r;
   endfunction

   // One clock cycle: present inputs, score the falling-edge view, then step.
   task automatic drive(input bit v, input longint a, input longint b,
                        input longint w, input bit sel, input bit rdy,
                        output bit acc);
      exp_t e;
      in_valid_i      = v;
      a_i             = a[W-1:0];
      b_i             = b[W-1:0];
      twiddle_i       = w[W-1:0];
      sel_butterfly_i = sel;
      out_ready_i     = rdy;
      @(negedge clk_i);
      if (hold_v) begin
         check("hold_valid", 64'(out_valid_o), 1);
         check("hold_a", 64'(a_o), 64'(hold_a));
         check("hold_b", 64'(b_o), 64'(hold_b));
         check("hold_err", 64'(range_err_o), 64'(hold_e));
      end
      if (out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid", 64'(out_valid_o), 0);
         end else begin
            e = exp_q.pop_front();
            check("range_err", 64'(range_err_o), 64'(e.err));
            if (!e.err) begin
               check("a_out", 64'(a_o), 64'(e.a));
               check("b_out", 64'(b_o), 64'(e.b));
            end
            if (e.lat_chk) check("latency", 64'(cyc - e.acc_edge + 1), 3);
         end
         exp_count++;
      end
      hold_v = out_valid_o && !out_ready_i;
      hold_a = a_o;
      hold_b = b_o;
      hold_e = range_err_o;
      acc = in_valid_i && in_ready_o;
      if (acc) begin
         e          = model(a, b, w, sel);
         e.acc_edge = cyc + 1;
         e.lat_chk  = check_lat;
         exp_q.push_back(e);
      end
      @(posedge clk_i);
      cyc++;
      #1;
      check("count", 64'(count_o), 64'(exp_count));
   endtask

   task automatic send(input longint a, input longint b, input longint w,
                       input bit sel);
      bit acc;
      int n;
      n = 0;
      do begin
         drive(1'b1, a, b, w, sel, 1'b1, acc);
         n++;
      end while (!acc && n < 20);
      check("send_accept", 64'(acc), 1);
   endtask

   task automatic drain();
      bit acc;
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         drive(1'b0, 0, 0, 0, 1'b0, 1'b1, acc);
         n++;
      end
      check("drain_empty", 64'(exp_q.size()), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acc;
      int          n, bp;
      logic [15:0] cnt0;
      longint      va[5], vb[5], vw[5];
      bit          vs[5];
      longint      ra, rb, rw;

      // ---- reset state
      #1;
      check("rst_in_ready", 64'(in_ready_o), 1);
      check("rst_out_valid", 64'(out_valid_o), 0);
      check("rst_a", 64'(a_o), 0);
      check("rst_b", 64'(b_o), 0);
      check("rst_err", 64'(range_err_o), 0);
      check("rst_count", 64'(count_o), 0);
      repeat (2) @(posedge clk_i);
      #2 rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;

      // ---- CT basic, latency 3
      check_lat = 1'b1;
      send(1, 2, 3, 1'b0);
      drain();
      check("ct_count", 64'(count_o), 1);

      // ---- GS basic and wrap, large product, CT wrap (back-to-back)
      send(5, 2, 3, 1'b1);
      send(Q-1, 1, 1, 1'b1);
      send(0, Q-1, Q-1, 1'b0);
      send(Q-1, 1, 1, 1'b0);
      drain();

      // ---- range flag on one vector only
      send(7, 11, 13, 1'b0);
      send(Q, 0, 0, 1'b0);
      send(100, 200, 300, 1'b1);
      drain();

      // ---- backpressure: consumer stalled for cycles 0-7
      check_lat = 1'b0;
      for (int i = 0; i < 5; i++) begin
         va[i] = $urandom_range(Q-1, 0);
         vb[i] = $urandom_range(Q-1, 0);
         vw[i] = $urandom_range(Q-1, 0);
         vs[i] = 1'(i % 2);
      end
      cnt0 = exp_count;
      bp   = 0;
      for (int i = 0; i < 5; i++) begin
         n = 0;
         do begin
            drive(1'b1, va[i], vb[i], vw[i], vs[i], bp >= 8, acc);
            bp++;
            n++;
         end while (!acc && n < 30);
         check("bp_accept", 64'(acc), 1);
         if (i == 2) check("bp_ready_low", 64'(in_ready_o), 0);
      end
      drain();
      check("bp_count", 64'(count_o), 64'(16'(cnt0 + 16'd5)));

      // ---- reset mid-stream with two vectors in flight
      check_lat = 1'b1;
      send(3, 4, 5, 1'b0);
      send(6, 7, 8, 1'b1);
      #1 rst_n_i = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid_o), 0);
      check("mid_rst_count", 64'(count_o), 0);
      check("mid_rst_ready", 64'(in_ready_o), 1);
      exp_q.delete();
      exp_count = '0;
      hold_v    = 1'b0;
      #1 rst_n_i = 1'b1;
      repeat (4) drive(1'b0, 0, 0, 0, 1'b0, 1'b1, acc);
      send(1234567, 7654321, 42, 1'b0);
      drain();

      // ---- random sweep with random valid and backpressure
      check_lat = 1'b0;
      for (int i = 0; i < 400; i++) begin
         ra = $urandom_range(Q-1, 0);
         rb = $urandom_range(Q-1, 0);
         rw = $urandom_range(Q-1, 0);
         if ($urandom_range(15, 0) == 0) ra = $urandom_range(2**W-1, Q);
         if ($urandom_range(31, 0) == 0) rw = $urandom_range(2**W-1, Q);
         drive($urandom_range(3, 0) != 0, ra, rb, rw, 1'($urandom_range(1, 0)),
               $urandom_range(3, 0) != 0, acc);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
